vend_fsm_param: RTL and testbench
=================================

Name: vend_fsm_param

Overview:
Parametrised successor to the fixed-price guffin vending FSM. Accepts quarter, half-dollar and dollar coin pulses and accumulates credit in quarter units. Vends a guffin once credit reaches a configurable price, then returns change one coin per cycle, half-dollars first. It sits after the coin debouncers and feeds the state/credit HEX display logic.

Parameters:
PRICE_Q, 3, guffin price in quarter units (3 = $0.75); legal range 1..12.
CREDIT_W, 4, credit register width; must hold PRICE_Q+3 (elaboration check).

Ports:
CLK  input  1  system clock; all state updates on rising edge.
RES  input  1  synchronous reset, active-high.
quarter_in  input  1  single-cycle pulse, 1 quarter unit.
halfDollar_in  input  1  single-cycle pulse, 2 quarter units.
dollar_in  input  1  single-cycle pulse, 4 quarter units.
cancel  input  1  single-cycle pulse, refund the accumulated credit.
guffin  output  1  high for one cycle per vend.
quarter_out  output  1  high for one cycle per returned quarter.
halfDollar_out  output  1  high for one cycle per returned half-dollar.
coin_reject  output  1  high for one cycle when an inserted coin is not credited.
busy  output  1  high in VEND or CHANGE.
credit  output  CREDIT_W  current credit in quarter units.
state_code  output  2  00 IDLE, 01 ACCUM, 10 VEND, 11 CHANGE (drives state_high/state_low display).

Behaviour:
- Reset: RES high at an edge sets state IDLE and credit 0. All outputs are 0 in the cycle after reset.
- Reset mid-operation: pending change is discarded and no coin is output.
- Outputs are Moore-decoded from the registered state and credit. There are no combinational paths from inputs to outputs, except coin_reject, which is registered one cycle after the offending coin.
- Coin sampling in IDLE/ACCUM:
  - Exactly one coin input high: credit += value at that edge.
  - More than one coin input high in the same cycle: nothing is credited, and coin_reject pulses the next cycle.
- Next state after a coin edge:
  - credit >= PRICE_Q: VEND.
  - 0 < credit < PRICE_Q: ACCUM.
- Coin credit is added with full width. Max credit is PRICE_Q-1+4, so no overflow for legal parameters.
- VEND (one cycle):
  - guffin = 1.
  - At the exit edge, credit -= PRICE_Q.
  - Then: credit after subtraction > 0 goes to CHANGE; = 0 goes to IDLE.
- CHANGE, each cycle:
  - credit >= 2: halfDollar_out = 1, and credit -= 2 at the edge.
  - credit == 1: quarter_out = 1, and credit -= 1 at the edge.
  - At the edge where credit reaches 0, go to IDLE.
  - Exactly one change output is high per CHANGE cycle.
- cancel:
  - In ACCUM: go to CHANGE at that edge without vending, refunding the full credit.
  - In IDLE, VEND or CHANGE: ignored.
  - cancel and a coin in the same ACCUM cycle: the coin is credited first, then the vend threshold is checked. If it is met, go to VEND; otherwise go to CHANGE, refunding the new total.
- Coins arriving in VEND/CHANGE are not credited and coin_reject pulses the next cycle.
- busy = state is VEND or CHANGE.

Optional Feature:
MULTI_VEND_EN
- Defined: at the VEND exit edge, if the remaining credit >= PRICE_Q, stay in VEND. Another guffin is issued each cycle until credit < PRICE_Q, then go to CHANGE or IDLE as above.
- Undefined: exactly one guffin per transaction. Any residual credit, even if >= PRICE_Q, is returned as change.

Test Plan:
1. PRICE_Q=3: quarter pulses at edges 1, 2, 3 -> credit 1, 2, 3; guffin high cycle 4 only; credit 0, IDLE at edge 4; no change outputs.
2. PRICE_Q=3: dollar at edge 1 -> VEND cycle 2 (guffin=1), CHANGE cycle 3 with quarter_out=1, IDLE with credit 0 after edge 3.
3. PRICE_Q=1, dollar, MULTI_VEND_EN undefined:
   - guffin pulses once.
   - Then halfDollar_out, then quarter_out, on consecutive cycles.
   - With MULTI_VEND_EN defined: guffin for 4 consecutive cycles, and no change.
4. PRICE_Q=3: half-dollar then cancel next cycle -> CHANGE, halfDollar_out=1 for one cycle, IDLE, guffin never high.
5. quarter_in and dollar_in high in the same cycle from IDLE -> credit stays 0, coin_reject=1 next cycle. A quarter inserted during CHANGE -> coin_reject=1, and the returned change count is unchanged.
6. RES asserted while in CHANGE with credit 2 -> next cycle state_code=00, credit=0, all outputs 0, no further change pulses.

Source files
------------

// File: rtl/vend_fsm_param.sv
// Parametrised guffin vending FSM: credits quarter/half/dollar pulses, vends at PRICE_Q, returns change.
// Optional feature macro: MULTI_VEND_EN (repeat vending while the remaining credit still covers the price).
module vend_fsm_param #(
  parameter int unsigned PRICE_Q  = 3,
  parameter int unsigned CREDIT_W = 4
) (
  input  logic                CLK,
  input  logic                RES,
  input  logic                quarter_in,
  input  logic                halfDollar_in,
  input  logic                dollar_in,
  input  logic                cancel,
  output logic                guffin,
  output logic                quarter_out,
  output logic                halfDollar_out,
  output logic                coin_reject,
  output logic                busy,
  output logic [CREDIT_W-1:0] credit,
  output logic [1:0]          state_code
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_ACCUM  = 2'b01,
    S_VEND   = 2'b10,
    S_CHANGE = 2'b11
  } state_e;

  localparam logic [CREDIT_W-1:0] PRICE = CREDIT_W'(PRICE_Q);
  localparam logic [CREDIT_W-1:0] ONE   = CREDIT_W'(1);
  localparam logic [CREDIT_W-1:0] TWO   = CREDIT_W'(2);
  localparam logic [CREDIT_W-1:0] FOUR  = CREDIT_W'(4);

  if (PRICE_Q < 1 || PRICE_Q > 12 || (PRICE_Q + 3) >= (1 << CREDIT_W)) begin : g_param_check
    $error("vend_fsm_param: PRICE_Q must be 1..12 and CREDIT_W must hold PRICE_Q+3");
  end

  state_e                state_q, state_d;
  logic [CREDIT_W-1:0]   credit_q, credit_d;
  logic                  coin_reject_q, coin_reject_d;
  logic                  any_coin, multi_coin;
  logic [CREDIT_W-1:0]   coin_val, sum, rem;

  always_comb begin
    any_coin   = quarter_in | halfDollar_in | dollar_in;
    multi_coin = (quarter_in & halfDollar_in) | (quarter_in & dollar_in) | (halfDollar_in & dollar_in);
    if (dollar_in)          coin_val = FOUR;
    else if (halfDollar_in) coin_val = TWO;
    else if (quarter_in)    coin_val = ONE;
    else                    coin_val = '0;
    sum = credit_q + coin_val;
    rem = credit_q - PRICE;

    state_d       = state_q;
    credit_d      = credit_q;
    coin_reject_d = 1'b0;

    unique case (state_q)
      S_IDLE, S_ACCUM: begin
        if (multi_coin) begin
          coin_reject_d = 1'b1;
          if (state_q == S_ACCUM && cancel) state_d = S_CHANGE;
        end else begin
          // Coin is credited before cancel is honoured, so a coin that reaches the price still vends.
          credit_d = sum;
          if (sum >= PRICE)                       state_d = S_VEND;
          else if (state_q == S_ACCUM && cancel)  state_d = S_CHANGE;
          else if (sum != '0)                     state_d = S_ACCUM;
        end
      end
      S_VEND: begin
        coin_reject_d = any_coin;
        credit_d      = rem;
`ifdef MULTI_VEND_EN
        if (rem >= PRICE)    state_d = S_VEND;
        else if (rem != '0)  state_d = S_CHANGE;
        else                 state_d = S_IDLE;
`else
        if (rem != '0)       state_d = S_CHANGE;
        else                 state_d = S_IDLE;
`endif
      end
      S_CHANGE: begin
        coin_reject_d = any_coin;
        if (credit_q >= TWO)      credit_d = credit_q - TWO;
        else if (credit_q != '0)  credit_d = credit_q - ONE;
        if (credit_d == '0) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RES) begin
      state_q       <= S_IDLE;
      credit_q      <= '0;
      coin_reject_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      credit_q      <= credit_d;
      coin_reject_q <= coin_reject_d;
    end
  end

  assign state_code     = state_q;
  assign credit         = credit_q;
  assign guffin         = (state_q == S_VEND);
  assign busy           = (state_q == S_VEND) || (state_q == S_CHANGE);
  assign halfDollar_out = (state_q == S_CHANGE) && (credit_q >= TWO);
  assign quarter_out    = (state_q == S_CHANGE) && (credit_q == ONE);
  assign coin_reject    = coin_reject_q;

endmodule

// File: tb/tb_vend_fsm_param.sv
// Directed bench for vend_fsm_param: one instance at PRICE_Q=3 and one at PRICE_Q=1 share the stimulus.
module tb_vend_fsm_param;

  logic       CLK = 1'b0;
  logic       RES = 1'b1;
  logic       quarter_in = 1'b0, halfDollar_in = 1'b0, dollar_in = 1'b0, cancel = 1'b0;

  logic       g3, q3, h3, r3, b3;
  logic [3:0] c3;
  logic [1:0] s3;
  logic       g1, q1, h1, r1, b1;
  logic [3:0] c1;
  logic [1:0] s1;

  int n_cmp = 0;
  int n_bad = 0;

  vend_fsm_param #(.PRICE_Q(3), .CREDIT_W(4)) dut (
    .CLK(CLK), .RES(RES), .quarter_in(quarter_in), .halfDollar_in(halfDollar_in),
    .dollar_in(dollar_in), .cancel(cancel), .guffin(g3), .quarter_out(q3),
    .halfDollar_out(h3), .coin_reject(r3), .busy(b3), .credit(c3), .state_code(s3)
  );

  vend_fsm_param #(.PRICE_Q(1), .CREDIT_W(4)) dut_p1 (
    .CLK(CLK), .RES(RES), .quarter_in(quarter_in), .halfDollar_in(halfDollar_in),
    .dollar_in(dollar_in), .cancel(cancel), .guffin(g1), .quarter_out(q1),
    .halfDollar_out(h1), .coin_reject(r1), .busy(b1), .credit(c1), .state_code(s1)
  );

  always #5 CLK = ~CLK;

  // Packed view: {state_code, credit, guffin, quarter_out, halfDollar_out, coin_reject, busy}
  function automatic logic [10:0] ev(input logic [1:0] s, input logic [3:0] c,
                                     input logic g, input logic q, input logic h, input logic r);
    ev = {s, c, g, q, h, r, s[1]};
  endfunction

  function automatic logic [10:0] obs3();
    obs3 = {s3, c3, g3, q3, h3, r3, b3};
  endfunction

  function automatic logic [10:0] obs1();
    obs1 = {s1, c1, g1, q1, h1, r1, b1};
  endfunction

  // Inputs applied at a falling edge are sampled by the next rising edge; outputs read at the falling edge after.
  task automatic step();
    @(negedge CLK);
    quarter_in = 1'b0; halfDollar_in = 1'b0; dollar_in = 1'b0; cancel = 1'b0;
  endtask

  task automatic do_reset();
    RES = 1'b1;
    step();
    RES = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if (obs3() !== ev(2'b00, 4'd0, 0, 0, 0, 0)) begin
      n_bad++; $display("FAIL reset_p3 got=%h want=%h", obs3(), ev(2'b00, 4'd0, 0, 0, 0, 0));
    end
    n_cmp++;
    if (obs1() !== ev(2'b00, 4'd0, 0, 0, 0, 0)) begin
      n_bad++; $display("FAIL reset_p1 got=%h want=%h", obs1(), ev(2'b00, 4'd0, 0, 0, 0, 0));
    end
  endtask

  task automatic test_quarters();
    logic [10:0] exp_v [4];
    exp_v[0] = ev(2'b01, 4'd1, 0, 0, 0, 0);
    exp_v[1] = ev(2'b01, 4'd2, 0, 0, 0, 0);
    exp_v[2] = ev(2'b10, 4'd3, 1, 0, 0, 0);
    exp_v[3] = ev(2'b00, 4'd0, 0, 0, 0, 0);
    do_reset();
    for (int i = 0; i < 4; i++) begin
      if (i < 3) quarter_in = 1'b1;
      step();
      n_cmp++;
      if (obs3() !== exp_v[i]) begin
        n_bad++; $display("FAIL quarters[%0d] got=%h want=%h", i, obs3(), exp_v[i]);
      end
    end
  endtask

  task automatic test_dollar_change();
    logic [10:0] exp_v [3];
    exp_v[0] = ev(2'b10, 4'd4, 1, 0, 0, 0);
    exp_v[1] = ev(2'b11, 4'd1, 0, 1, 0, 0);
    exp_v[2] = ev(2'b00, 4'd0, 0, 0, 0, 0);
    do_reset();
    dollar_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp++;
      if (obs3() !== exp_v[i]) begin
        n_bad++; $display("FAIL dollar_change[%0d] got=%h want=%h", i, obs3(), exp_v[i]);
      end
    end
  endtask

  task automatic test_price1_dollar();
    logic [10:0] exp_v [5];
`ifdef MULTI_VEND_EN
    exp_v[0] = ev(2'b10, 4'd4, 1, 0, 0, 0);
    exp_v[1] = ev(2'b10, 4'd3, 1, 0, 0, 0);
    exp_v[2] = ev(2'b10, 4'd2, 1, 0, 0, 0);
    exp_v[3] = ev(2'b10, 4'd1, 1, 0, 0, 0);
    exp_v[4] = ev(2'b00, 4'd0, 0, 0, 0, 0);
`else
    exp_v[0] = ev(2'b10, 4'd4, 1, 0, 0, 0);
    exp_v[1] = ev(2'b11, 4'd3, 0, 0, 1, 0);
    exp_v[2] = ev(2'b11, 4'd1, 0, 1, 0, 0);
    exp_v[3] = ev(2'b00, 4'd0, 0, 0, 0, 0);
    exp_v[4] = ev(2'b00, 4'd0, 0, 0, 0, 0);
`endif
    do_reset();
    dollar_in = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      n_cmp++;
      if (obs1() !== exp_v[i]) begin
        n_bad++; $display("FAIL price1_dollar[%0d] got=%h want=%h", i, obs1(), exp_v[i]);
      end
    end
  endtask

  task automatic test_cancel();
    do_reset();
    cancel = 1'b1;
    step();
    n_cmp++;
    if (obs3() !== ev(2'b00, 4'd0, 0, 0, 0, 0)) begin
      n_bad++; $display("FAIL cancel_idle got=%h want=%h", obs3(), ev(2'b00, 4'd0, 0, 0, 0, 0));
    end
    halfDollar_in = 1'b1;
    step();
    cancel = 1'b1;
    step();
    n_cmp++;
    if (obs3() !== ev(2'b11, 4'd2, 0, 0, 1, 0)) begin
      n_bad++; $display("FAIL cancel_refund got=%h want=%h", obs3(), ev(2'b11, 4'd2, 0, 0, 1, 0));
    end
    step();
    n_cmp++;
    if (obs3() !== ev(2'b00, 4'd0, 0, 0, 0, 0)) begin
      n_bad++; $display("FAIL cancel_done got=%h want=%h", obs3(), ev(2'b00, 4'd0, 0, 0, 0, 0));
    end
  endtask

  task automatic test_cancel_with_coin();
    do_reset();
    quarter_in = 1'b1;
    step();
    halfDollar_in = 1'b1; cancel = 1'b1;
    step();
    n_cmp++;
    if (obs3() !== ev(2'b10, 4'd3, 1, 0, 0, 0)) begin
      n_bad++; $display("FAIL cancel_coin_vend got=%h want=%h", obs3(), ev(2'b10, 4'd3, 1, 0, 0, 0));
    end
    step();
    quarter_in = 1'b1;
    step();
    quarter_in = 1'b1; cancel = 1'b1;
    step();
    n_cmp++;
    if (obs3() !== ev(2'b11, 4'd2, 0, 0, 1, 0)) begin
      n_bad++; $display("FAIL cancel_coin_refund got=%h want=%h", obs3(), ev(2'b11, 4'd2, 0, 0, 1, 0));
    end
  endtask

  task automatic test_reject();
    int n_half, n_qtr;
    do_reset();
    quarter_in = 1'b1; dollar_in = 1'b1;
    step();
    n_cmp++;
    if (obs3() !== ev(2'b00, 4'd0, 0, 0, 0, 1)) begin
      n_bad++; $display("FAIL reject_multi got=%h want=%h", obs3(), ev(2'b00, 4'd0, 0, 0, 0, 1));
    end
    step();
    n_cmp++;
    if (obs3() !== ev(2'b00, 4'd0, 0, 0, 0, 0)) begin
      n_bad++; $display("FAIL reject_clear got=%h want=%h", obs3(), ev(2'b00, 4'd0, 0, 0, 0, 0));
    end
    // Credit 6 -> vend leaves 3: half then quarter; a quarter inserted in CHANGE must not add to it.
    quarter_in = 1'b1;
    step();
    quarter_in = 1'b1;
    step();
    dollar_in = 1'b1;
    step();
    step();
    n_cmp++;
    if (obs3() !== ev(2'b11, 4'd3, 0, 0, 1, 0)) begin
      n_bad++; $display("FAIL reject_change_start got=%h want=%h", obs3(), ev(2'b11, 4'd3, 0, 0, 1, 0));
    end
    n_half = 1; n_qtr = 0;
    quarter_in = 1'b1;
    step();
    n_cmp++;
    if (obs3() !== ev(2'b11, 4'd1, 0, 1, 0, 1)) begin
      n_bad++; $display("FAIL reject_in_change got=%h want=%h", obs3(), ev(2'b11, 4'd1, 0, 1, 0, 1));
    end
    for (int i = 0; i < 6; i++) begin
      n_half += int'(h3); n_qtr += int'(q3);
      step();
    end
    n_cmp++;
    if (n_half != 1 || n_qtr != 1 || s3 !== 2'b00 || c3 !== 4'd0) begin
      n_bad++; $display("FAIL reject_change_count got=h%0d/q%0d/s%b/c%0d want=h1/q1/s00/c0",
                        n_half, n_qtr, s3, c3);
    end
  endtask

  task automatic test_reset_in_change();
    do_reset();
    halfDollar_in = 1'b1;
    step();
    cancel = 1'b1;
    step();
    n_cmp++;
    if (obs3() !== ev(2'b11, 4'd2, 0, 0, 1, 0)) begin
      n_bad++; $display("FAIL rst_change_setup got=%h want=%h", obs3(), ev(2'b11, 4'd2, 0, 0, 1, 0));
    end
    RES = 1'b1;
    step();
    RES = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (obs3() !== ev(2'b00, 4'd0, 0, 0, 0, 0)) begin
        n_bad++; $display("FAIL rst_change[%0d] got=%h want=%h", i, obs3(), ev(2'b00, 4'd0, 0, 0, 0, 0));
      end
      step();
    end
  endtask

  initial begin
    test_reset();
    test_quarters();
    test_dollar_change();
    test_price1_dollar();
    test_cancel();
    test_cancel_with_coin();
    test_reject();
    test_reset_in_change();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
